// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin arbiter that lets two requesters share one
// external multiplier. Each operation goes IDLE -> ISSUE -> WAIT -> DONE.
//
// Optional feature: define MULT_ARB_LATCHK_EN to enable the latency checker.
// The checker sets the sticky lat_err flag when m_done arrives on the wrong
// cycle. It also forces completion with product = 0 when m_done never arrives.
// Without the macro, lat_err is tied low and WAIT waits indefinitely.
//
// Handshake: m_start is a one-cycle strobe issued in ISSUE. The multiplier
// answers with a one-cycle m_done carrying m_product, and m_done is honoured
// only in WAIT. Operands on m_multiplier/m_multiplicand are stable from ISSUE
// through DONE. done0/done1 are one-cycle pulses in DONE, and product is
// valid from then on until the next completion.
module multiplier_arbiter #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   multiplier0,
  input  logic [WIDTH-1:0]   multiplier1,
  input  logic [WIDTH-1:0]   multiplicand0,
  input  logic [WIDTH-1:0]   multiplicand1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               m_start,
  output logic [WIDTH-1:0]   m_multiplier,
  output logic [WIDTH-1:0]   m_multiplicand,
  input  logic [2*WIDTH-1:0] m_product,
  input  logic               m_done,
  output logic               lat_err,
  output logic [1:0]         state_dbg
);

  // The counter must reach LATENCY+2 and also form counter+1 without wrapping.
  localparam int CW = $clog2(LATENCY + 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;   // requester being served
  logic               last_q, last_d;     // requester served most recently
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      cnt_inc;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               m_start_q, m_start_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               gnt;
`ifdef MULT_ARB_LATCHK_EN
  logic               lat_err_q, lat_err_d;
`endif

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state and next-output logic for the arbitration/operation sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    mult_d    = mult_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    m_start_d = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    gnt       = 1'b0;
`ifdef MULT_ARB_LATCHK_EN
    lat_err_d = lat_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins; otherwise the only requester wins.
          gnt       = (req0 && req1) ? ~last_q : req1;
          grant_d   = gnt;
          last_d    = gnt;
          mult_d    = gnt ? multiplier1   : multiplier0;
          mcand_d   = gnt ? multiplicand1 : multiplicand0;
          m_start_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (m_done) begin
          prod_d  = m_product;
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = DONE;
`ifdef MULT_ARB_LATCHK_EN
          if (cnt_inc != CW'(LATENCY)) lat_err_d = 1'b1;
`endif
        end
`ifdef MULT_ARB_LATCHK_EN
        else if (cnt_q == CW'(LATENCY + 2)) begin
          // The multiplier never answered: complete anyway with a zero result.
          lat_err_d = 1'b1;
          prod_d    = '0;
          cnt_d     = cnt_q;
          done0_d   = ~grant_q;
          done1_d   = grant_q;
          state_d   = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      mult_q    <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      m_start_q <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MULT_ARB_LATCHK_EN
      lat_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      mult_q    <= mult_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      m_start_q <= m_start_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
`ifdef MULT_ARB_LATCHK_EN
      lat_err_q <= lat_err_d;
`endif
    end
  end

  assign done0          = done0_q;
  assign done1          = done1_q;
  assign product        = prod_q;
  assign busy           = busy_q;
  assign m_start        = m_start_q;
  assign m_multiplier   = mult_q;
  assign m_multiplicand = mcand_q;
  assign state_dbg      = state_q;
`ifdef MULT_ARB_LATCHK_EN
  assign lat_err        = lat_err_q;
`else
  assign lat_err        = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: directed table of single operations plus hand-written
// sequences for tie fairness, early request drop, stray m_done, mid-operation
// reset and latency checking. A behavioural shared multiplier answers m_start.
module tb_multiplier_arbiter;

  localparam int W   = 4;
  localparam int LAT = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   multiplier0 = '0, multiplier1 = '0;
  logic [W-1:0]   multiplicand0 = '0, multiplicand1 = '0;
  logic           done0, done1, busy, m_start, lat_err;
  logic [2*W-1:0] product;
  logic [W-1:0]   m_multiplier, m_multiplicand;
  logic [2*W-1:0] m_product = '0;
  logic           m_done = 1'b0;
  logic [1:0]     state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Multiplier model state: answer delay (0 = never answers), countdown, bookkeeping.
  int             model_lat = LAT;
  int             cd = 0;
  logic [2*W-1:0] pend = '0;
  int             start_cnt = 0;
  int             start_cyc = 0;
  logic           spur_req = 1'b0;

  multiplier_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .multiplier0(multiplier0), .multiplier1(multiplier1),
    .multiplicand0(multiplicand0), .multiplicand1(multiplicand1),
    .done0(done0), .done1(done1), .product(product), .busy(busy),
    .m_start(m_start), .m_multiplier(m_multiplier), .m_multiplicand(m_multiplicand),
    .m_product(m_product), .m_done(m_done), .lat_err(lat_err), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier model: m_done is driven high for one cycle, model_lat
  // cycles after the cycle in which m_start is high.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (!rst) begin
      cd = 0;
    end else begin
      if (spur_req) begin
        m_done    = 1'b1;
        m_product = 8'hAB;
        spur_req  = 1'b0;
      end
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          m_done    = 1'b1;
          m_product = pend;
        end
      end
      if (m_start) begin
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
        pend      = (2*W)'(m_multiplier) * (2*W)'(m_multiplicand);
        if (model_lat > 0) cd = model_lat;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a done pulse; which = 0/1, 2 if both, -1 on timeout.
  task automatic wait_done(output int which, output int at_cyc);
    which  = -1;
    at_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        which  = (done0 && done1) ? 2 : (done1 ? 1 : 0);
        at_cyc = cyc;
        break;
      end
    end
    if (which < 0) begin
      failures++;
      $display("FAIL done_timeout actual=none required=pulse");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_ops(input logic [W-1:0] a0, b0, a1, b1);
    multiplier0 = a0; multiplicand0 = b0;
    multiplier1 = a1; multiplicand1 = b1;
  endtask

  typedef struct {
    logic           r0;
    logic           r1;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    int             g;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int which, dc, prev_dc, pulses;

    // {req0, req1, a0, b0, a1, b1, expected grant, expected product}
    tbl[0] = '{1'b1, 1'b0, 4'd7,  4'd9,  4'd0,  4'd0,  0, 8'd63};
    tbl[1] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd15, 4'd15, 1, 8'd225};
    tbl[2] = '{1'b1, 1'b1, 4'd0,  4'd13, 4'd3,  4'd5,  0, 8'd0};
    tbl[3] = '{1'b1, 1'b1, 4'd2,  4'd3,  4'd15, 4'd14, 1, 8'd210};
    tbl[4] = '{1'b1, 1'b1, 4'd15, 4'd1,  4'd9,  4'd9,  0, 8'd15};
    tbl[5] = '{1'b1, 1'b0, 4'd8,  4'd8,  4'd1,  4'd1,  0, 8'd64};
    tbl[6] = '{1'b1, 1'b1, 4'd4,  4'd4,  4'd6,  4'd7,  1, 8'd42};

    // Reset state while rst is held low.
    #1;
    check("reset_outputs",
          32'({state_dbg, busy, m_start, done0, done1, lat_err, product, m_multiplier, m_multiplicand}),
          32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Table of single operations.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_ops(tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      req0 = tbl[i].r0;
      req1 = tbl[i].r1;
      start_cnt = 0;
      wait_done(which, dc);
      req0 = 1'b0;
      req1 = 1'b0;
      check($sformatf("vec%0d_grant", i), 32'(which), 32'(tbl[i].g));
      check($sformatf("vec%0d_product", i), 32'(product), 32'(tbl[i].p));
      check($sformatf("vec%0d_start_once", i), 32'(start_cnt), 32'd1);
      check($sformatf("vec%0d_latency", i), 32'(dc - start_cyc), 32'(LAT + 1));
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 32'({done0, done1, busy, lat_err}), 32'd0);
    end

    // Tie fairness with both requests held continuously from reset.
    do_reset();
    set_ops(4'd3, 4'd4, 4'd5, 4'd6);
    req0 = 1'b1;
    req1 = 1'b1;
    prev_dc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(which, dc);
      check($sformatf("tie%0d_grant", k), 32'(which), 32'(k % 2));
      check($sformatf("tie%0d_product", k), 32'(product), (k % 2 == 0) ? 32'd12 : 32'd30);
      if (k > 0) check($sformatf("tie%0d_spacing", k), 32'(dc - prev_dc), 32'(LAT + 3));
      prev_dc = dc;
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Early drop: req1 removed during WAIT, operand inputs changed as well.
    @(negedge clk);
    set_ops(4'd9, 4'd9, 4'd5, 4'd6);
    req1 = 1'b1;
    repeat (2) @(negedge clk);
    req1 = 1'b0;
    multiplier1 = 4'd0;
    multiplicand1 = 4'd0;
    @(negedge clk);
    check("drop_operands_stable", 32'({m_multiplier, m_multiplicand}), 32'({4'd5, 4'd6}));
    check("drop_in_wait", 32'({busy, state_dbg}), 32'({1'b1, 2'd2}));
    wait_done(which, dc);
    check("drop_grant", 32'(which), 32'd1);
    check("drop_product", 32'(product), 32'd30);
    @(negedge clk);
    req0 = 1'b1;
    req1 = 1'b1;
    wait_done(which, dc);
    req0 = 1'b0;
    req1 = 1'b0;
    check("after_drop_grant", 32'(which), 32'd0);
    check("after_drop_product", 32'(product), 32'd81);

    // Stray m_done while IDLE is ignored.
    @(negedge clk);
    spur_req = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || done1 || busy) pulses++;
    end
    check("stray_mdone_ignored", 32'(pulses), 32'd0);
    check("stray_mdone_product", 32'(product), 32'd81);

    // Mid-operation reset.
    @(negedge clk);
    set_ops(4'd3, 4'd3, 4'd2, 4'd2);
    req0 = 1'b1;
    repeat (3) @(negedge clk);
    req0 = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset_outputs",
          32'({state_dbg, busy, m_start, done0, done1, lat_err, product, m_multiplier, m_multiplicand}),
          32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0 || done1) pulses++;
    end
    check("midreset_no_done", 32'(pulses), 32'd0);
    req0 = 1'b1;
    req1 = 1'b1;
    wait_done(which, dc);
    req0 = 1'b0;
    req1 = 1'b0;
    check("midreset_tie_grant", 32'(which), 32'd0);
    check("midreset_tie_product", 32'(product), 32'd9);

    // Latency checking.
    @(negedge clk);
    model_lat = 4;
    set_ops(4'd2, 4'd3, 4'd0, 4'd0);
    req0 = 1'b1;
    wait_done(which, dc);
    req0 = 1'b0;
    check("early_grant", 32'(which), 32'd0);
    check("early_product", 32'(product), 32'd6);
`ifdef MULT_ARB_LATCHK_EN
    check("early_lat_err", 32'(lat_err), 32'd1);
    @(negedge clk);
    model_lat = LAT;
    req0 = 1'b1;
    wait_done(which, dc);
    req0 = 1'b0;
    check("lat_err_sticky", 32'(lat_err), 32'd1);
    do_reset();
    #1;
    check("lat_err_cleared", 32'(lat_err), 32'd0);
    @(negedge clk);
    model_lat = 0;
    req0 = 1'b1;
    wait_done(which, dc);
    req0 = 1'b0;
    check("absent_grant", 32'(which), 32'd0);
    check("absent_product", 32'(product), 32'd0);
    check("absent_lat_err", 32'(lat_err), 32'd1);
    check("absent_timeout_cycle", 32'(dc - start_cyc), 32'(LAT + 4));
`else
    check("early_lat_err", 32'(lat_err), 32'd0);
    @(negedge clk);
    model_lat = 0;
    req0 = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || done1) pulses++;
    end
    req0 = 1'b0;
    check("absent_no_done", 32'(pulses), 32'd0);
    check("absent_still_wait", 32'({busy, state_dbg, lat_err}), 32'({1'b1, 2'd2, 1'b0}));
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter LATENCY, default 5, giving the required cycle count from m_start asserted to m_done asserted.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req0 / req1, input, 1 bit each: requester 0/1 operation request.
REQ-007 The block SHALL have port multiplier0 / multiplier1, input, WIDTH bits: requester operand A.
REQ-008 The block SHALL have port multiplicand0 / multiplicand1, input, WIDTH bits: requester operand B.
REQ-009 The block SHALL have port done0 / done1, output, 1 bit: one-cycle completion pulse to requester 0/1.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: result, valid in the done0/done1 cycle and held until the next completion.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have ports m_start (output, 1 bit), m_multiplier (output, WIDTH bits) and m_multiplicand (output, WIDTH bits) to the shared multiplier.
REQ-013 The block SHALL have ports m_product (input, 2*WIDTH bits) and m_done (input, 1 bit) from the shared multiplier.
REQ-014 The block SHALL have port lat_err, output, 1 bit: sticky latency violation flag.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE with any req high, the block SHALL grant one requester, latch its operands into m_multiplier/m_multiplicand, record the grant index, and go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: when req0 and req1 are both high, the grant goes to the requester not served last; after reset, requester 0 wins the first tie.
REQ-018 ISSUE SHALL assert m_start for exactly one cycle, clear the cycle counter, and go to WAIT.
REQ-019 m_multiplier and m_multiplicand SHALL stay stable from ISSUE through DONE.
REQ-020 WAIT SHALL increment the counter each cycle; on m_done it SHALL capture m_product into product and go to DONE.
REQ-021 DONE SHALL pulse done0 or done1 (granted index only) for one cycle and return to IDLE.
REQ-022 Throughput SHALL be one operation per LATENCY+3 cycles; a new grant is possible only in the cycle after DONE.
REQ-023 A req deasserted mid-operation SHALL NOT abort the operation; the done pulse is still issued.
REQ-024 A requester holding req high after its done SHALL be treated as a new request.
REQ-025 m_done outside WAIT SHALL be ignored.
REQ-026 product SHALL be exactly m_product, with no truncation.

Reset
REQ-027 While rst is low, the FSM SHALL be in IDLE and m_start, done0, done1, busy and lat_err SHALL be 0.
REQ-028 While rst is low, product, m_multiplier, m_multiplicand and the counter SHALL be 0 and the last-served pointer SHALL be 1, so requester 0 wins the first tie.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done pulse.

Configuration
REQ-030 With macro MULT_ARB_LATCHK_EN defined, lat_err SHALL set when m_done arrives with counter+1 != LATENCY.
REQ-031 With MULT_ARB_LATCHK_EN defined, lat_err SHALL also set when the counter reaches LATENCY+2 with no m_done; the FSM then goes to DONE with product = 0 and still pulses done.
REQ-032 lat_err SHALL clear only on reset.
REQ-033 Without MULT_ARB_LATCHK_EN, lat_err SHALL be tied to 0, and WAIT SHALL wait indefinitely for m_done.

Verification
REQ-034 Single request: WIDTH=4, req0=1, operands 7 and 9, model m_done after 5 cycles -> product=63, done0 pulses once, done1 stays 0, lat_err=0.
REQ-035 Tie fairness: req0 and req1 held high continuously -> grants alternate 0,1,0,1 and the first grant after reset goes to 0.
REQ-036 Boundary operands: 15 and 15 -> product=225; 0 and 13 -> product=0.
REQ-037 Early drop: req1 drops during WAIT -> done1 still pulses and the next grant is unaffected.
REQ-038 Mid-operation reset: rst pulled low during WAIT -> all outputs 0 immediately, no done pulse, next tie goes to requester 0.
REQ-039 Latency check (MULT_ARB_LATCHK_EN defined): m_done at cycle 4, or absent -> lat_err=1 and stays 1; without the macro, lat_err stays 0.
